// File: rtl/sram_1024x32_req_ctrl.sv
// Valid/ready request front end for the 1024x32 single-port SRAM macro, with an in-order response FIFO.
// Latency: response visible 2 edges after request acceptance; 1 request/cycle sustained when resp_ready is high.
// Backpressure: req_ready drops once FIFO entries plus the in-flight access fill RESP_DEPTH, unless a pop frees a slot.
module sram_1024x32_req_ctrl #(
    parameter int BITS       = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int RESP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    input  logic [BITS/8-1:0]     req_wstrb,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [BITS-1:0]       resp_rdata,

    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd
);

    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic                 r_pending;
    logic                 r_pending_write;
    logic                 r_fifo_write [RESP_DEPTH];
    logic [BITS-1:0]      r_fifo_rdata [RESP_DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_fire;
    logic                 w_push;
    logic                 w_pop;
    logic [CW:0]          w_occ;
    logic [BITS-1:0]      w_wmask;
    logic [BITS-1:0]      w_push_rdata;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    for (genvar i = 0; i < BITS/8; i++) begin : g_wmask
        assign w_wmask[8*i +: 8] = {8{req_wstrb[i]}};
    end

    // The in-flight access already owns a FIFO slot, so it counts against space.
    assign resp_valid = (r_count != '0);
    assign w_pop      = resp_valid & resp_ready;
    assign w_occ      = {1'b0, r_count} + (CW+1)'(r_pending);
    assign req_ready  = (w_occ < (CW+1)'(RESP_DEPTH)) | w_pop;
    assign w_fire     = req_valid & req_ready;

    assign sram_ce    = w_fire;
    assign sram_we    = w_fire & req_write;
    assign sram_addr  = w_fire ? req_addr  : '0;
    assign sram_wd    = w_fire ? req_wdata : '0;
    assign sram_wmask = (w_fire & req_write) ? w_wmask : '0;

    // rd_out is only meaningful the cycle after a read; writes return zero data.
    assign w_push       = r_pending;
    assign w_push_rdata = r_pending_write ? '0 : sram_rd;

    assign resp_write = resp_valid & r_fifo_write[r_rd_ptr];
    assign resp_rdata = resp_valid ? r_fifo_rdata[r_rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending       <= 1'b0;
            r_pending_write <= 1'b0;
        end else begin
            r_pending       <= w_fire;
            r_pending_write <= w_fire & req_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Entry storage needs no reset: outputs are gated by resp_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_write[r_wr_ptr] <= r_pending_write;
            r_fifo_rdata[r_wr_ptr] <= w_push_rdata;
        end
    end

endmodule
